hs_sync: RTL and testbench

//  Two-phase req/ack handshake CDC for an N-bit word from domain A (clkA) to domain B (clkB).
//  - Source word is held in an A-side register until B acknowledges, so multi-bit data is never sampled mid-change.
//  - Gives the A side busy/done status and the B side a one-cycle valid strobe.
//  - Sits between an A-domain producer and a B-domain consumer in the synchronizer test designs.

---
 rtl/hs_sync.sv | 110 +++++++++++
 tb/tb_hs_sync.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync.sv
// Two-phase req/ack handshake moving an N-bit word from the clkA domain to the clkB domain.
// Optional saturating count of rejected sends is enabled by defining HS_SYNC_DROP_CNT_EN.
module hs_sync #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clkA,
    input  logic         rst_n,
    input  logic         clkB,
    input  logic         enaA,
    input  logic         enaB,
    input  logic         send_in,
    input  logic [N-1:0] data_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [N-1:0] data_out,
    output logic         valid_out
`ifdef HS_SYNC_DROP_CNT_EN
    ,
    output logic [7:0]   drop_cnt
`endif
);

    // A-domain state
    logic              req_tgl_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [N-1:0]      hold_reg;
    logic [STAGES-1:0] ack_sync_reg;
    logic              ack_s;

    // B-domain state
    logic [STAGES-1:0] req_sync_reg;
    logic              req_s;
    logic              r_d_reg;
    logic              ack_tgl_reg;
    logic              valid_reg;
    logic [N-1:0]      data_reg;

    assign ack_s = ack_sync_reg[STAGES-1];
    assign req_s = req_sync_reg[STAGES-1];

    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            req_tgl_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hold_reg    <= '0;
        end else if (enaA) begin
            done_reg <= 1'b0;
            if (busy_reg && (ack_s == req_tgl_reg)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end else if (send_in && !busy_reg) begin
                // hold_reg stays frozen until the ack toggle comes back
                hold_reg    <= data_in;
                req_tgl_reg <= ~req_tgl_reg;
                busy_reg    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_reg <= '0;
        end else if (enaA) begin
            ack_sync_reg <= {ack_sync_reg[STAGES-2:0], ack_tgl_reg};
        end
    end

`ifdef HS_SYNC_DROP_CNT_EN
    logic [7:0] drop_reg;

    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            drop_reg <= 8'd0;
        end else if (enaA && send_in && busy_reg && (drop_reg != 8'hFF)) begin
            drop_reg <= drop_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_reg;
`endif

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_reg <= '0;
            r_d_reg      <= 1'b0;
            ack_tgl_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
        end else if (enaB) begin
            req_sync_reg <= {req_sync_reg[STAGES-2:0], req_tgl_reg};
            valid_reg    <= 1'b0;
            if (req_s != r_d_reg) begin
                // hold_reg is quiet here because the A side waits for our ack
                data_reg    <= hold_reg;
                valid_reg   <= 1'b1;
                ack_tgl_reg <= req_s;
                r_d_reg     <= req_s;
            end
        end
    end

    assign busy_out  = busy_reg;
    assign done_out  = done_reg;
    assign data_out  = data_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_hs_sync.sv
// Randomised self-checking bench for hs_sync against a transfer-level scoreboard model.
`timescale 1ns/100ps
module tb_hs_sync;
    localparam int N = 8;

    logic         clkA = 1'b0;
    logic         clkB = 1'b0;
    logic         rst_n = 1'b0;
    logic         enaA = 1'b1;
    logic         enaB = 1'b1;
    logic         send_in = 1'b0;
    logic [N-1:0] data_in = '0;
    logic         busy_out;
    logic         done_out;
    logic [N-1:0] data_out;
    logic         valid_out;
`ifdef HS_SYNC_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    realtime half_b = 8.5;

    int n_checks = 0;
    int n_fail   = 0;

    // transfer-level model
    logic [N-1:0] pend_q[$];
    bit           model_busy = 0;
    bit           chk_lat    = 0;
    int           unacked    = 0;
    int           a_edges    = 0;
    int           b_edges    = 0;
    int           valid_cnt  = 0;
    int           done_cnt   = 0;
    int           acc_cnt    = 0;
    int           model_drop = 0;
    int           acc_b_edge = 0;
    int           valid_a_edge = 0;
    logic [N-1:0] last_word  = '0;

    hs_sync #(.N(N), .STAGES(2)) dut (
        .clkA      (clkA),
        .rst_n     (rst_n),
        .clkB      (clkB),
        .enaA      (enaA),
        .enaB      (enaB),
        .send_in   (send_in),
        .data_in   (data_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .data_out  (data_out),
        .valid_out (valid_out)
`ifdef HS_SYNC_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clkA = ~clkA;

    // fractional phase keeps clkB edges off clkA edges at every period used
    initial begin
        #0.3;
        forever #(half_b) clkB = ~clkB;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // A-side model: acceptance, drop counting, done bookkeeping, busy check
    always @(posedge clkA) begin
        logic         s;
        logic [N-1:0] d;
        bit           mb;
        bit           live;
        int           be;
        a_edges++;
        be   = b_edges;
        s    = send_in;
        d    = data_in;
        mb   = model_busy;
        live = rst_n && enaA;
        if (live) begin
            if (s && mb && model_drop < 255) model_drop++;
            if (s && !mb) begin
                pend_q.push_back(d);
                model_busy = 1;
                acc_cnt++;
                acc_b_edge = be;
            end
        end
        #0.2;
        if (rst_n && live) begin
            if (done_out) begin
                check_eq("done_has_delivery", unacked > 0, 1);
                if (unacked > 0) unacked--;
                done_cnt++;
                if (chk_lat) check_eq("done_latency", a_edges - valid_a_edge, 3);
                model_busy = 0;
            end
            check_eq("busy", busy_out, model_busy);
        end
    end

    // B-side scoreboard: each valid must deliver the oldest accepted word
    always @(posedge clkB) begin
        int           ae;
        int           be;
        bit           eb;
        logic [N-1:0] exp_w;
        b_edges++;
        be = b_edges;
        ae = a_edges;
        eb = enaB;
        #0.2;
        if (rst_n && eb && valid_out) begin
            valid_cnt++;
            valid_a_edge = ae;
            if (pend_q.size() == 0) begin
                check_eq("valid_unexpected", 1, 0);
            end else begin
                exp_w = pend_q.pop_front();
                check_eq("data_out", data_out, exp_w);
                last_word = exp_w;
                unacked++;
                if (chk_lat) check_eq("valid_latency", be - acc_b_edge, 3);
            end
        end
    end

    task automatic send_word(input logic [N-1:0] w);
        @(negedge clkA);
        send_in = 1'b1;
        data_in = w;
        @(negedge clkA);
        send_in = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy_out || model_busy) && n < max_cyc) begin
            @(negedge clkA);
            n++;
        end
        check_eq("idle_timeout", n < max_cyc, 1);
    endtask

    task automatic random_run(input realtime hb, input int n_sends);
        int a0, v0, d0, n;
        half_b = hb;
        repeat (4) @(negedge clkA);
        a0 = acc_cnt;
        v0 = valid_cnt;
        d0 = done_cnt;
        n  = 0;
        chk_lat = 1;
        while (n < 40000) begin
            @(negedge clkA);
            if (acc_cnt - a0 >= n_sends) break;
            send_in = ($urandom_range(0, 3) != 0);
            data_in = N'($urandom);
            n++;
        end
        send_in = 1'b0;
        wait_idle(500);
        repeat (4) @(negedge clkA);
        check_eq("rnd_accepted", acc_cnt - a0, n_sends);
        check_eq("rnd_valid_cnt", valid_cnt - v0, n_sends);
        check_eq("rnd_done_cnt", done_cnt - d0, n_sends);
        check_eq("rnd_pending", pend_q.size(), 0);
        check_eq("rnd_last_word", data_out, last_word);
`ifdef HS_SYNC_DROP_CNT_EN
        check_eq("rnd_drop_cnt", drop_cnt, model_drop);
`endif
        $display("random run clkB half=%0.1f ns: %0d words transferred", hb, valid_cnt - v0);
    endtask

    initial begin
        int vc, dc, n;

        // reset behaviour
        rst_n = 1'b0;
        repeat (5) @(negedge clkA);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_done", done_out, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_data", data_out, 0);
`ifdef HS_SYNC_DROP_CNT_EN
        check_eq("rst_drop", drop_cnt, 0);
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clkA);
        check_eq("idle_valid_cnt", valid_cnt, 0);
        check_eq("idle_busy", busy_out, 0);
        $display("reset test done");

        // single transfer with latency checks
        chk_lat = 1;
        send_word(8'hA5);
        wait_idle(200);
        repeat (5) @(negedge clkB);
        check_eq("single_valid_cnt", valid_cnt, 1);
        check_eq("single_done_cnt", done_cnt, 1);
        check_eq("single_hold_a5", data_out, 8'hA5);
        $display("single transfer A5 done");

        // send held high while busy: second word waits for done
        vc = valid_cnt;
        @(negedge clkA);
        send_in = 1'b1;
        data_in = 8'h01;
        @(negedge clkA);
        data_in = 8'h02;
        n = 0;
        while (model_busy && n < 200) begin
            @(negedge clkA);
            n++;
        end
        check_eq("hold_send_timeout", n < 200, 1);
        check_eq("first_only", valid_cnt - vc, 1);
        check_eq("first_word", last_word, 8'h01);
        @(negedge clkA);
        send_in = 1'b0;
        wait_idle(200);
        repeat (5) @(negedge clkB);
        check_eq("second_delivered", valid_cnt - vc, 2);
        check_eq("second_word", data_out, 8'h02);
`ifdef HS_SYNC_DROP_CNT_EN
        check_eq("drop_cnt_busy_sends", drop_cnt, model_drop);
`endif
        $display("held send test done, drops modelled=%0d", model_drop);

        // enaB low stalls the transfer without loss
        chk_lat = 0;
        vc = valid_cnt;
        send_word(8'h3C);
        enaB = 1'b0;
        repeat (50) @(negedge clkB);
        check_eq("stall_busy", busy_out, 1);
        check_eq("stall_no_valid", valid_cnt - vc, 0);
        enaB = 1'b1;
        wait_idle(200);
        repeat (5) @(negedge clkB);
        check_eq("stall_delivered_once", valid_cnt - vc, 1);
        check_eq("stall_word", data_out, 8'h3C);
        $display("enaB stall test done");

        // reset mid-transfer abandons it
        vc = valid_cnt;
        dc = done_cnt;
        send_word(8'h5A);
        rst_n = 1'b0;
        pend_q.delete();
        model_busy = 0;
        unacked    = 0;
        model_drop = 0;
        last_word  = '0;
        repeat (2) @(negedge clkA);
        rst_n = 1'b1;
        repeat (30) @(negedge clkA);
        check_eq("abort_no_valid", valid_cnt - vc, 0);
        check_eq("abort_no_done", done_cnt - dc, 0);
        check_eq("abort_data", data_out, 0);
        check_eq("abort_busy", busy_out, 0);
        $display("mid-transfer reset test done");

        // randomised traffic at a fast and a slow destination clock
        random_run(1.5, 1000);
        random_run(20.5, 1000);
        check_eq("total_valid_eq_done", valid_cnt, done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
